// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the translation front end.
// Provides the uTLB entry layout, translation result payloads, the refill
// FSM state enum and the mapped-region decode helper.
package cpu_defs;

  localparam int unsigned VADDR_W    = 32;
  localparam int unsigned VPN_W      = 20;
  localparam int unsigned PFN_W      = 20;
  localparam int unsigned ASID_W     = 8;
  localparam int unsigned PAGE_OFF_W = 12;

  // One cached translation of a 4 KiB page.
  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              glob;
    logic [PFN_W-1:0]  pfn;
    logic              dirty;
    logic              valid;
  } UtlbEntry_t;

  // Per-channel translation result handed back to the pipeline.
  typedef struct packed {
    logic               dirty;
    logic               miss;
    logic               invalid;
    logic               illegal;
    logic [VADDR_W-1:0] phy_addr;
  } MMUResult_t;

  // Lookup response from the main TLB.
  typedef struct packed {
    logic               miss;
    logic               valid;
    logic               dirty;
    logic               glob;
    logic [VADDR_W-1:0] phy_addr;
  } TLBResult_t;

  typedef enum logic [1:0] {
    REFILL_IDLE,
    REFILL_REQ,
    REFILL_WAIT
  } refill_state_e;

  // Mapped segments: useg (bit31 clear) and kseg2/kseg3 (top bits 2'b11).
  function automatic logic is_vaddr_mapped(input logic [1:0] seg);
    return !seg[1] || (seg == 2'b11);
  endfunction

endpackage

// File: rtl/utlb_array.sv
// One channel's fully-associative micro-TLB.
// Ports:
//   clk, rst        clock, async active-low reset
//   flush_i         clear every valid bit on the next edge (beats a fill)
//   vpn_i, asid_i   lookup key for the combinational match
//   hit_c_o, pfn_c_o, dirty_c_o  combinational match result
//   fill_en_i, fill_i            write fill_i into the victim slot
module utlb_array
  import cpu_defs::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [VPN_W-1:0]  vpn_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              fill_en_i,
  input  UtlbEntry_t        fill_i,
  output logic              hit_c_o,
  output logic [PFN_W-1:0]  pfn_c_o,
  output logic              dirty_c_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  UtlbEntry_t [ENTRIES-1:0] entry_q, entry_d;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic [IDX_W-1:0]         victim;
  logic                     found_free;

  // Associative match: valid, VPN equal, and either global or same ASID.
  always_comb begin
    hit_c_o   = 1'b0;
    pfn_c_o   = '0;
    dirty_c_o = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (entry_q[i].valid && (entry_q[i].vpn == vpn_i) &&
          (entry_q[i].glob || (entry_q[i].asid == asid_i))) begin
        hit_c_o   = 1'b1;
        pfn_c_o   = entry_q[i].pfn;
        dirty_c_o = entry_q[i].dirty;
      end
    end
  end

  // Victim: lowest-index free slot, else the round-robin pointer.
  always_comb begin
    found_free = 1'b0;
    victim     = rr_q;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!found_free && !entry_q[i].valid) begin
        found_free = 1'b1;
        victim     = IDX_W'(i);
      end
    end
  end

  // Next-state for storage: flush clears valids and suppresses any fill.
  always_comb begin
    entry_d = entry_q;
    rr_d    = rr_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entry_d[i].valid = 1'b0;
      end
    end else if (fill_en_i) begin
      entry_d[victim] = fill_i;
      rr_d            = rr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      rr_q    <= '0;
    end else begin
      entry_q <= entry_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: rtl/mmu_utlb.sv
// Address-translation front end with a private uTLB per channel and a
// shared, single-outstanding refill path to the main TLB.
// Ports:
//   clk, rst                 clock, async active-low reset
//   asid, is_user_mode       current context
//   flush                    invalidate all uTLB entries and fault registers
//   req, vaddr               per-channel translation request
//   stall, result            per-channel combinational translation outcome
//   tlb_req_valid/ready/vaddr  refill request handshake
//   tlb_resp_valid, tlb_resp   one-cycle refill response
module mmu_utlb
  import cpu_defs::*;
#(
  parameter int unsigned N_PORTS      = 2,
  parameter int unsigned UTLB_ENTRIES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ASID_W-1:0]                asid,
  input  logic                             is_user_mode,
  input  logic                             flush,
  input  logic [N_PORTS-1:0]               req,
  input  logic [N_PORTS-1:0][VADDR_W-1:0]  vaddr,
  output logic [N_PORTS-1:0]               stall,
  output MMUResult_t [N_PORTS-1:0]         result,
  output logic                             tlb_req_valid,
  input  logic                             tlb_req_ready,
  output logic [VADDR_W-1:0]               tlb_req_vaddr,
  input  logic                             tlb_resp_valid,
  input  TLBResult_t                       tlb_resp
);

  localparam int unsigned CH_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  refill_state_e       state_q, state_d;
  logic [CH_W-1:0]     owner_q, owner_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [VADDR_W-1:0]  req_vaddr_q, req_vaddr_d;
  logic [ASID_W-1:0]   req_asid_q, req_asid_d;
  logic                req_valid_q, req_valid_d;
  logic                discard_q, discard_d;

  logic [N_PORTS-1:0]  need;
  logic [N_PORTS-1:0]  pending;
  logic                grant_valid;
  logic [CH_W-1:0]     grant_idx;
  logic                busy;
  logic                resp_take;
  logic                resp_good;
  UtlbEntry_t          fill_entry;
  logic                unused_resp_off;

  function automatic logic [CH_W-1:0] wrap_idx(input int unsigned base,
                                               input int unsigned off);
    return CH_W'((base + off) % N_PORTS);
  endfunction

  assign busy      = (state_q != REFILL_IDLE);
  // A response is consumed only if no flush has hit this refill.
  assign resp_take = (state_q == REFILL_WAIT) && tlb_resp_valid && !discard_q && !flush;
  assign resp_good = !tlb_resp.miss && tlb_resp.valid;

  assign fill_entry.vpn   = req_vaddr_q[VADDR_W-1:PAGE_OFF_W];
  assign fill_entry.asid  = req_asid_q;
  assign fill_entry.glob  = tlb_resp.glob;
  assign fill_entry.pfn   = tlb_resp.phy_addr[VADDR_W-1:PAGE_OFF_W];
  assign fill_entry.dirty = tlb_resp.dirty;
  assign fill_entry.valid = 1'b1;

  assign unused_resp_off = ^tlb_resp.phy_addr[PAGE_OFF_W-1:0];

  for (genvar c = 0; c < N_PORTS; c++) begin : g_ch
    logic              mapped;
    logic              own;
    logic              hit;
    logic              hit_dirty;
    logic [PFN_W-1:0]  hit_pfn;
    logic              fault_hit;
    logic              fault_set;
    logic              fault_valid_q;
    logic              fault_miss_q;
    logic [VPN_W-1:0]  fault_vpn_q;
    MMUResult_t        res;

    utlb_array #(
      .ENTRIES (UTLB_ENTRIES)
    ) u_array (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush),
      .vpn_i     (vaddr[c][VADDR_W-1:PAGE_OFF_W]),
      .asid_i    (asid),
      .fill_en_i (resp_take && resp_good && own),
      .fill_i    (fill_entry),
      .hit_c_o   (hit),
      .pfn_c_o   (hit_pfn),
      .dirty_c_o (hit_dirty)
    );

    assign mapped    = is_vaddr_mapped(vaddr[c][VADDR_W-1:VADDR_W-2]);
    assign own       = busy && (owner_q == CH_W'(c));
    assign fault_set = resp_take && !resp_good && own;
    assign fault_hit = fault_valid_q && req[c] &&
                       (fault_vpn_q == vaddr[c][VADDR_W-1:PAGE_OFF_W]);

    // Result decode: unmapped passthrough, uTLB hit, or latched fault.
    always_comb begin
      res         = '0;
      res.invalid = is_user_mode && vaddr[c][VADDR_W-1];
      if (!mapped) begin
        res.phy_addr = {3'b000, vaddr[c][VADDR_W-4:0]};
        res.dirty    = 1'b1;
      end else if (hit) begin
        res.phy_addr = {hit_pfn, vaddr[c][PAGE_OFF_W-1:0]};
        res.dirty    = hit_dirty;
      end else if (fault_hit) begin
        res.miss    = fault_miss_q;
        res.illegal = !fault_miss_q;
      end
    end

    assign result[c]  = res;
    assign need[c]    = req[c] && mapped && !hit && !fault_hit;
    // The channel being refilled is not re-arbitrated until the FSM is idle.
    assign pending[c] = need[c] && !own;

    // Fault register: holds a failed lookup while the same page is requested.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fault_valid_q <= 1'b0;
        fault_miss_q  <= 1'b0;
        fault_vpn_q   <= '0;
      end else if (flush) begin
        fault_valid_q <= 1'b0;
      end else if (fault_set) begin
        fault_valid_q <= 1'b1;
        fault_miss_q  <= tlb_resp.miss;
        fault_vpn_q   <= req_vaddr_q[VADDR_W-1:PAGE_OFF_W];
      end else if (fault_valid_q &&
                   (!req[c] || (fault_vpn_q != vaddr[c][VADDR_W-1:PAGE_OFF_W]))) begin
        fault_valid_q <= 1'b0;
      end
    end
  end

  assign stall = need;

  // Round-robin grant: rr_q is the highest-priority channel this round.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!grant_valid && pending[wrap_idx(rr_q, i)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_idx(rr_q, i);
      end
    end
  end

  // Refill FSM next-state and registered request outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    req_vaddr_d = req_vaddr_q;
    req_asid_d  = req_asid_q;
    req_valid_d = 1'b0;
    discard_d   = discard_q || flush;
    unique case (state_q)
      REFILL_IDLE: begin
        discard_d = 1'b0;
        if (grant_valid) begin
          state_d     = REFILL_REQ;
          owner_d     = grant_idx;
          rr_d        = wrap_idx(grant_idx, 1);
          req_vaddr_d = vaddr[grant_idx];
          req_asid_d  = asid;
          req_valid_d = 1'b1;
        end
      end
      REFILL_REQ: begin
        req_valid_d = 1'b1;
        if (tlb_req_ready) begin
          state_d     = REFILL_WAIT;
          req_valid_d = 1'b0;
        end
      end
      REFILL_WAIT: begin
        if (tlb_resp_valid) begin
          state_d = REFILL_IDLE;
        end
      end
      default: state_d = REFILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= REFILL_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      req_vaddr_q <= '0;
      req_asid_q  <= '0;
      req_valid_q <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      req_vaddr_q <= req_vaddr_d;
      req_asid_q  <= req_asid_d;
      req_valid_q <= req_valid_d;
      discard_q   <= discard_d;
    end
  end

  assign tlb_req_valid = req_valid_q;
  assign tlb_req_vaddr = req_vaddr_q;

endmodule

// File: tb/tb_mmu_utlb.sv
// Directed bench for mmu_utlb with two channels and four-entry uTLBs.
module tb_mmu_utlb;
  import cpu_defs::*;

  localparam int unsigned NP = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [7:0]              asid;
  logic                    is_user_mode;
  logic                    flush;
  logic [NP-1:0]           req;
  logic [NP-1:0][31:0]     vaddr;
  logic [NP-1:0]           stall;
  MMUResult_t [NP-1:0]     result;
  logic                    tlb_req_valid;
  logic                    tlb_req_ready;
  logic [31:0]             tlb_req_vaddr;
  logic                    tlb_resp_valid;
  TLBResult_t              tlb_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmu_utlb #(.N_PORTS(NP), .UTLB_ENTRIES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .asid           (asid),
    .is_user_mode   (is_user_mode),
    .flush          (flush),
    .req            (req),
    .vaddr          (vaddr),
    .stall          (stall),
    .result         (result),
    .tlb_req_valid  (tlb_req_valid),
    .tlb_req_ready  (tlb_req_ready),
    .tlb_req_vaddr  (tlb_req_vaddr),
    .tlb_resp_valid (tlb_resp_valid),
    .tlb_resp       (tlb_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic MMUResult_t mk_res(input logic d, input logic m, input logic inv,
                                        input logic il, input logic [31:0] pa);
    MMUResult_t r;
    r = '0;
    r.dirty = d; r.miss = m; r.invalid = inv; r.illegal = il; r.phy_addr = pa;
    return r;
  endfunction

  function automatic TLBResult_t ok_resp(input logic [19:0] pfn, input logic d, input logic g);
    TLBResult_t r;
    r = '0;
    r.valid = 1'b1; r.dirty = d; r.glob = g; r.phy_addr = {pfn, 12'h000};
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b0; asid = '0; is_user_mode = 1'b0; flush = 1'b0; req = '0; vaddr = '0;
    tlb_req_ready = 1'b0; tlb_resp_valid = 1'b0; tlb_resp = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Waits (bounded) for a refill request, accepts it, and responds gap cycles later.
  // lat = cycles until tlb_req_valid was seen, or -1 on timeout.
  task automatic serve(input TLBResult_t r, input int gap, output logic [31:0] seen, output int lat);
    int n;
    n = 0; seen = '0; lat = -1;
    while (!tlb_req_valid && n < 20) begin tick(); n++; end
    if (tlb_req_valid) begin
      lat = n; seen = tlb_req_vaddr;
      tlb_req_ready = 1'b1; tick(); tlb_req_ready = 1'b0;
      repeat (gap - 1) tick();
      tlb_resp_valid = 1'b1; tlb_resp = r; tick();
      tlb_resp_valid = 1'b0; tlb_resp = '0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (tlb_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", tlb_req_valid); end
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL reset_stall: got %b want 00", stall); end
    n_tests++; if (result[0] !== mk_res(0, 0, 0, 0, 32'h0)) begin n_fail++; $display("FAIL reset_result0: got %h want %h", result[0], mk_res(0, 0, 0, 0, 32'h0)); end
    n_tests++; if (result[1] !== mk_res(0, 0, 0, 0, 32'h0)) begin n_fail++; $display("FAIL reset_result1: got %h want %h", result[1], mk_res(0, 0, 0, 0, 32'h0)); end
  endtask

  task automatic test_unmapped();
    vaddr[0] = 32'h8000_1234; req = 2'b01; #1;
    n_tests++; if (result[0] !== mk_res(1, 0, 0, 0, 32'h0000_1234)) begin n_fail++; $display("FAIL unmapped_kseg0: got %h want %h", result[0], mk_res(1, 0, 0, 0, 32'h0000_1234)); end
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL unmapped_stall: got %b want 00", stall); end
    repeat (3) tick();
    n_tests++; if (tlb_req_valid !== 1'b0) begin n_fail++; $display("FAIL unmapped_no_refill: got %b want 0", tlb_req_valid); end
    is_user_mode = 1'b1; vaddr[0] = 32'hA000_0010; #1;
    n_tests++; if (result[0] !== mk_res(1, 0, 1, 0, 32'h0000_0010)) begin n_fail++; $display("FAIL unmapped_user_invalid: got %h want %h", result[0], mk_res(1, 0, 1, 0, 32'h0000_0010)); end
    is_user_mode = 1'b0; req = '0; tick();
  endtask

  task automatic test_cold_miss();
    logic [31:0] seen; int lat;
    vaddr[0] = 32'h0040_0123; req = 2'b01; #1;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL cold_stall_c0: got %b want 01", stall); end
    n_tests++; if (tlb_req_valid !== 1'b0) begin n_fail++; $display("FAIL cold_req_c0: got %b want 0", tlb_req_valid); end
    serve(ok_resp(20'h01234, 1'b0, 1'b0), 3, seen, lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL cold_req_latency: got %0d want 1", lat); end
    n_tests++; if (seen !== 32'h0040_0123) begin n_fail++; $display("FAIL cold_req_vaddr: got %h want 00400123", seen); end
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL cold_stall_after: got %b want 00", stall); end
    n_tests++; if (result[0] !== mk_res(0, 0, 0, 0, 32'h0123_4123)) begin n_fail++; $display("FAIL cold_result: got %h want %h", result[0], mk_res(0, 0, 0, 0, 32'h0123_4123)); end
    vaddr[0] = 32'h0040_0FFF; #1;
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL repeat_stall: got %b want 00", stall); end
    n_tests++; if (result[0].phy_addr !== 32'h0123_4FFF) begin n_fail++; $display("FAIL repeat_phy: got %h want 01234fff", result[0].phy_addr); end
    tick();
    n_tests++; if (tlb_req_valid !== 1'b0) begin n_fail++; $display("FAIL repeat_no_refill: got %b want 0", tlb_req_valid); end
    req = '0; tick();
  endtask

  task automatic test_fault();
    logic [31:0] seen; int lat;
    TLBResult_t bad;
    bad = '0;
    vaddr[0] = 32'h0000_2000; req = 2'b01; #1;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL fault_stall_c0: got %b want 01", stall); end
    serve(bad, 1, seen, lat);
    n_tests++; if (lat < 0) begin n_fail++; $display("FAIL fault_timeout: got %0d want >=0", lat); end
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL fault_stall_after: got %b want 00", stall); end
    n_tests++; if (result[0] !== mk_res(0, 0, 0, 1, 32'h0)) begin n_fail++; $display("FAIL fault_result: got %h want %h", result[0], mk_res(0, 0, 0, 1, 32'h0)); end
    tick();
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL fault_hold: got %b want 00", stall); end
    vaddr[0] = 32'h0000_3000; #1;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL fault_vpn_change: got %b want 01", stall); end
    serve(ok_resp(20'h00033, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0000_3000) begin n_fail++; $display("FAIL fault_rereq_vaddr: got %h want 00003000", seen); end
    vaddr[0] = 32'h0000_2000; #1;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL fault_no_entry: got %b want 01", stall); end
    serve(ok_resp(20'h00022, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (result[0].phy_addr !== 32'h0002_2000) begin n_fail++; $display("FAIL fault_refill_phy: got %h want 00022000", result[0].phy_addr); end
    req = '0; tick();
  endtask

  task automatic test_dual_miss();
    logic [31:0] seen; int lat;
    do_reset();
    vaddr[0] = 32'h0010_0000; vaddr[1] = 32'h0020_0000; req = 2'b11; #1;
    n_tests++; if (stall !== 2'b11) begin n_fail++; $display("FAIL dual_stall: got %b want 11", stall); end
    serve(ok_resp(20'h00100, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0010_0000) begin n_fail++; $display("FAIL dual_first_grant: got %h want 00100000", seen); end
    n_tests++; if (stall !== 2'b10) begin n_fail++; $display("FAIL dual_ch1_waits: got %b want 10", stall); end
    serve(ok_resp(20'h00200, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL dual_ch1_latency: got %0d want 1", lat); end
    n_tests++; if (seen !== 32'h0020_0000) begin n_fail++; $display("FAIL dual_second_grant: got %h want 00200000", seen); end
    n_tests++; if (result[1] !== mk_res(1, 0, 0, 0, 32'h0020_0000)) begin n_fail++; $display("FAIL dual_ch1_result: got %h want %h", result[1], mk_res(1, 0, 0, 0, 32'h0020_0000)); end
    req = 2'b01; vaddr[0] = 32'h0030_0000; #1;
    serve(ok_resp(20'h00300, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0030_0000) begin n_fail++; $display("FAIL solo_grant: got %h want 00300000", seen); end
    vaddr[0] = 32'h0040_0000; vaddr[1] = 32'h0050_0000; req = 2'b11; #1;
    serve(ok_resp(20'h00500, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0050_0000) begin n_fail++; $display("FAIL rr_ch1_first: got %h want 00500000", seen); end
    serve(ok_resp(20'h00400, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0040_0000) begin n_fail++; $display("FAIL rr_ch0_second: got %h want 00400000", seen); end
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL rr_stall_after: got %b want 00", stall); end
    req = '0; tick();
  endtask

  task automatic test_flush();
    logic [31:0] seen; int lat;
    do_reset();
    vaddr[1] = 32'h0060_0000; req = 2'b10; #1;
    serve(ok_resp(20'h00600, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL flush_ch1_cached: got %b want 00", stall); end
    req = 2'b01; vaddr[0] = 32'h0070_0000; #1;
    tick();
    n_tests++; if (tlb_req_valid !== 1'b1) begin n_fail++; $display("FAIL flush_req_up: got %b want 1", tlb_req_valid); end
    tlb_req_ready = 1'b1; tick(); tlb_req_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tlb_resp_valid = 1'b1; tlb_resp = ok_resp(20'h00700, 1'b1, 1'b0); tick();
    tlb_resp_valid = 1'b0; tlb_resp = '0;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL flush_discard: got %b want 01", stall); end
    tick();
    flush = 1'b1; #1;
    n_tests++; if (tlb_req_valid !== 1'b1) begin n_fail++; $display("FAIL flush_rereq: got %b want 1", tlb_req_valid); end
    tick(); flush = 1'b0;
    n_tests++; if (tlb_req_valid !== 1'b1 || tlb_req_vaddr !== 32'h0070_0000) begin n_fail++; $display("FAIL flush_req_held: got %b/%h want 1/00700000", tlb_req_valid, tlb_req_vaddr); end
    tlb_req_ready = 1'b1; tick(); tlb_req_ready = 1'b0;
    tlb_resp_valid = 1'b1; tlb_resp = ok_resp(20'h00700, 1'b1, 1'b0); tick();
    tlb_resp_valid = 1'b0; tlb_resp = '0;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL flush_req_discard: got %b want 01", stall); end
    serve(ok_resp(20'h00701, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0070_0000) begin n_fail++; $display("FAIL flush_third_req: got %h want 00700000", seen); end
    n_tests++; if (result[0].phy_addr !== 32'h0070_1000) begin n_fail++; $display("FAIL flush_refill_phy: got %h want 00701000", result[0].phy_addr); end
    req = 2'b11; #1;
    n_tests++; if (stall !== 2'b10) begin n_fail++; $display("FAIL flush_other_ch_miss: got %b want 10", stall); end
    serve(ok_resp(20'h00600, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (seen !== 32'h0060_0000) begin n_fail++; $display("FAIL flush_other_ch_req: got %h want 00600000", seen); end
    req = '0; tick();
  endtask

  task automatic test_asid_reset();
    logic [31:0] seen; int lat;
    asid = 8'd5; vaddr[0] = 32'h0080_0000; req = 2'b01; #1;
    serve(ok_resp(20'h00800, 1'b1, 1'b0), 1, seen, lat);
    n_tests++; if (stall !== 2'b00) begin n_fail++; $display("FAIL asid5_hit: got %b want 00", stall); end
    asid = 8'd6; #1;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL asid6_miss: got %b want 01", stall); end
    tick();
    n_tests++; if (tlb_req_valid !== 1'b1) begin n_fail++; $display("FAIL asid6_req: got %b want 1", tlb_req_valid); end
    rst = 1'b0; #1;
    n_tests++; if (tlb_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_drops_req: got %b want 0", tlb_req_valid); end
    tick(); rst = 1'b1; asid = 8'd5; #1;
    n_tests++; if (stall !== 2'b01) begin n_fail++; $display("FAIL reset_clears_entries: got %b want 01", stall); end
    req = '0; tick();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_unmapped();
    test_cold_miss();
    test_fault();
    test_dual_miss();
    test_flush();
    test_asid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
